// File: rtl/zigzag_buffer_if.sv
// Coefficient-in / block-out bundle for zigzag_buffer: raster input handshake,
// parallel zigzag block output with ack, and the fill counter.
interface zigzag_buffer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] data_out [0:63];
    logic              valid_out;
    logic              out_ack;
    logic [5:0]        wr_count;

    modport master (
        output in_valid, in_data, out_ack,
        input  in_ready, data_out, valid_out, wr_count
    );

    modport slave (
        input  in_valid, in_data, out_ack,
        output in_ready, data_out, valid_out, wr_count
    );
endinterface

// File: rtl/zigzag_buffer.sv
// Raster-to-zigzag 8x8 block buffer. Define ZIGZAG_PINGPONG_EN for two banks
// (fill one while the other is held); otherwise a single bank fills then holds.
module zigzag_buffer #(
    parameter int unsigned DATA_W = 8
) (
    input logic           clk_in,
    input logic           rst_in,
    zigzag_buffer_if.slave bus
);
    typedef enum logic {FILL, FULL} bank_state_t;

    // Raster index -> zigzag position.
    localparam int unsigned ZZ [64] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

    logic [5:0] wr_cnt;
    logic [5:0] zz_pos;
    logic       accept;
    logic       ack_hit;

    always_comb zz_pos = 6'(ZZ[wr_cnt]);

    assign bus.wr_count = wr_cnt;

`ifdef ZIGZAG_PINGPONG_EN
    logic [DATA_W-1:0] mem [2][64];
    bank_state_t       state [2];
    logic              wr_ptr;
    logic              rd_ptr;

    assign bus.in_ready  = (state[wr_ptr] == FILL);
    assign bus.valid_out = (state[rd_ptr] == FULL);
    assign accept        = bus.in_valid && bus.in_ready;
    assign ack_hit       = bus.out_ack && bus.valid_out;

    always_comb begin
        for (int unsigned i = 0; i < 64; i++) bus.data_out[i] = mem[rd_ptr][i];
    end

    // accept and ack_hit always target different banks when both fire,
    // so the two state updates below never collide.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned b = 0; b < 2; b++) begin
                state[b] <= FILL;
                for (int unsigned i = 0; i < 64; i++) mem[b][i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            wr_cnt <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr][zz_pos] <= bus.in_data;
                wr_cnt              <= wr_cnt + 6'd1;
                if (wr_cnt == 6'd63) begin
                    state[wr_ptr] <= FULL;
                    wr_ptr        <= ~wr_ptr;
                end
            end
            if (ack_hit) begin
                state[rd_ptr] <= FILL;
                rd_ptr        <= ~rd_ptr;
            end
        end
    end
`else
    logic [DATA_W-1:0] mem [64];
    bank_state_t       state;

    assign bus.in_ready  = (state == FILL);
    assign bus.valid_out = (state == FULL);
    assign accept        = bus.in_valid && bus.in_ready;
    assign ack_hit       = bus.out_ack && bus.valid_out;

    always_comb begin
        for (int unsigned i = 0; i < 64; i++) bus.data_out[i] = mem[i];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= FILL;
            for (int unsigned i = 0; i < 64; i++) mem[i] <= '0;
            wr_cnt <= '0;
        end else begin
            if (accept) begin
                mem[zz_pos] <= bus.in_data;
                wr_cnt      <= wr_cnt + 6'd1;
                if (wr_cnt == 6'd63) state <= FULL;
            end
            if (ack_hit) state <= FILL;
        end
    end
`endif
endmodule

// File: doc/zigzag_buffer.md
# zigzag_buffer

Upstream neighbour of the run-length encoder in the JPEG path. Accepts one quantized coefficient per cycle in raster (row-major) order over a valid/ready handshake and writes it into a 64-entry block buffer at its JPEG zigzag position. Presents each completed block as a parallel `data_out[0:63]` array, held stable with `valid_out` high until the consumer acknowledges it. With the ping-pong option, the next block fills while the current one is held.

## Interface
Parameters:
- `DATA_W`, default 8: coefficient width (bits). Values are passed through unmodified.

Ports:
- `clk_in`: input, 1 bit. Clock.
- `rst_in`: input, 1 bit. Reset, asynchronous, active-high.
- `in_valid`: input, 1 bit. `in_data` is valid this cycle.
- `in_data`: input, `DATA_W` bits. Coefficient, raster order within the 8x8 block.
- `in_ready`: output, 1 bit. The block can accept a coefficient this cycle.
- `data_out[0:63]`: output, 64 x `DATA_W` bits. Zigzag-ordered block being presented.
- `valid_out`: output, 1 bit. `data_out` holds a complete block; it is stable while this is high.
- `out_ack`: input, 1 bit. Single-cycle pulse; the consumer releases the presented block.
- `wr_count`: output, 6 bits. Number of coefficients accepted into the block currently filling.

## Operation
- **Accept.** A coefficient is accepted on a rising edge when `in_valid && in_ready`.
  - Its raster index is `wr_count`, and it is written to bank entry `zz[wr_count]`.
  - `wr_count` increments mod 64.
- **Zigzag map.** `zz` is the standard JPEG zigzag table, a 64-entry constant ROM. Anchor entries:
  - `zz[0]=0`, `zz[1]=1`, `zz[8]=2`, `zz[16]=3`, `zz[9]=4`, `zz[2]=5`
  - `zz[7]=28`, `zz[56]=35`, `zz[63]=63`
- **Bank states.** Each bank is either FILL or FULL.
  - FILL→FULL on the edge that accepts raster index 63.
  - FULL→FILL on the edge where `out_ack` is high and that bank is the one presented.
- **Pointers.**
  - The write pointer toggles to the other bank when a bank becomes FULL.
  - The read pointer toggles when the presented bank is acked.
- **Handshake outputs** (both combinational from state):
  - `in_ready` = (write bank is FILL).
  - `valid_out` = (read bank is FULL).
  - `data_out` = contents of the read bank.
- **Ignored ack.** `out_ack` while `valid_out` is low has no effect.
- **Simultaneous events.** If the 64th accept into bank B and the ack of bank A occur on the same edge:
  - A→FILL and B→FULL.
  - The read pointer moves to B, so `valid_out` stays high and `data_out` shows B from the next cycle.
  - `in_ready` stays high, with writes continuing into A.
- **Bank contents.** Banks are not cleared between blocks; every entry is overwritten by the next fill.
- **Reset** (asserted at any time):
  - Both banks clear to 0 and go to FILL.
  - `wr_count`=0 and both pointers = bank 0.
  - Any partial block is discarded; a block being held is dropped.
- **Output values during and after reset:** `valid_out`=0, `data_out` all 0, `in_ready`=1, `wr_count`=0.

## Timing
- Throughput is 1 coefficient/cycle.
- With ping-pong enabled and the consumer acking promptly, there are no bubbles between blocks.
- Latency: `valid_out` rises in the cycle immediately after the edge that accepted raster index 63.
- `data_out` is the registered bank content, so it changes only at clock edges.
- After an ack edge, `valid_out` falls in the next cycle unless the other bank is FULL.
- After an ack edge, `in_ready` rises in the next cycle if it was low.
- The consumer may hold `valid_out` indefinitely; the upstream then stalls with `in_ready`=0 and `wr_count` frozen.

## Configuration
- **`ZIGZAG_PINGPONG_EN` defined:** two banks, behaviour as above.
- **Undefined:** a single bank, which is both the write and the read bank.
  - `in_ready` = !`valid_out`, so fill and hold never overlap.
  - The ack edge returns the bank to FILL, and `in_ready` is 1 the following cycle.
  - The minimum block period is 64 + 1 + (consumer hold) cycles.

## Test plan
- **Raster stream:** stream raster values 0..63 back-to-back after reset → `valid_out` high on the cycle after the 64th accept.
  - `data_out[2]`=8, `data_out[5]`=2, `data_out[28]`=7, `data_out[35]`=56, `data_out[63]`=63.
- **Held output, ping-pong on:** hold `out_ack` low for 200 cycles after block 1, then stream block 2.
  - Block 2 is fully accepted; `in_ready` drops after its 64th accept.
  - `data_out` stays block 1 throughout.
  - Ack → `data_out`=block 2 next cycle, `valid_out` stays 1, `in_ready`=1.
- **Coincident edge:** ack block 1 on the exact edge accepting block 2's index 63 → `valid_out` is never low, and block 2 is presented the next cycle.
- **Single bank** (macro undefined): after block 1 completes, `in_ready`=0 until ack.
  - Pulse ack → `in_ready`=1 the next cycle and `valid_out`=0.
  - A second ack while `valid_out`=0 has no effect.
- **Reset mid-block:** assert `rst_in` asynchronously after 30 accepts → all outputs reach reset values immediately.
  - After release, a fresh 64-sample block completes normally.
- **Throttled input:** random `in_valid` gaps and all-equal data (value 5) → a block of all 5s, with `wr_count` advancing only on accepted cycles.
